// File: rtl/bw_clk_pkg.sv
// Shared definitions for the cluster-clock divider family: FSM state
// constants, default counter width and the ratio clamp helper.
package bw_clk_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int unsigned DIV_MIN = 2;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_STOPPING = 2'd1;
  localparam logic [1:0] ST_STOPPED  = 2'd2;

  // Ratios below DIV_MIN cannot form a two-phase clock, so they are raised to it.
  function automatic int unsigned clamp_ratio(input int unsigned r);
    return (r < DIV_MIN) ? DIV_MIN : r;
  endfunction

endpackage

// File: rtl/bw_clk_cclk_div_cnt.sv
// Period counter and high-phase compare for the cclk divider.
// Counts 0..N-1 while run=1; the registered cclk_div is high for the first
// H=(N+1)>>1 counts of each period. While held, the outputs park low and the
// counter rests at N-1 so that the next running edge starts a fresh period.
module bw_clk_cclk_div_cnt
  import bw_clk_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = 2
) (
  input  logic             gclk,
  input  logic             arst,
  input  logic [CNT_W-1:0] n,
  input  logic [CNT_W-1:0] n_new,
  input  logic             run,
  input  logic             load,
  output logic [CNT_W-1:0] cnt_next,
  output logic             cclk_div,
  output logic             cyc_start
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_len;

  // Next count with wrap at N-1, and the high-phase length (odd N favours high).
  always_comb begin
    cnt_next = (cnt == n - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
    high_len = (n >> 1) + CNT_W'(n[0]);
  end

  // Advance and register the divided clock, or park low and rest at N-1.
  always_ff @(posedge gclk or posedge arst) begin
    if (arst) begin
      cnt       <= CNT_W'(DIV_RST - 1);
      cclk_div  <= 1'b0;
      cyc_start <= 1'b0;
    end else if (run) begin
      cnt       <= cnt_next;
      cclk_div  <= (cnt_next < high_len);
      cyc_start <= (cnt_next == '0);
    end else begin
      cclk_div  <= 1'b0;
      cyc_start <= 1'b0;
      if (load) begin
        cnt <= n_new - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bw_clk_cclk_div.sv
// Programmable integer divider and stop/start controller for the cclk path.
// Ratio changes use a level req / pulse ack handshake and only take effect
// on a period boundary, so cclk_div never emits a runt pulse.
// Optional feature macro: BW_CLK_CCLK_DIV_STOP_EN enables the controlled
// stop (STOPPING/STOPPED states, stop_req, stopped). Without it the block
// always runs and stopped is tied low.
module bw_clk_cclk_div
  import bw_clk_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = 2
) (
  input  logic             gclk,
  input  logic             arst,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic             div_req,
  output logic             div_ack,
  input  logic             stop_req,
  output logic             stopped,
  output logic             cclk_div,
  output logic             cyc_start
);

  logic [CNT_W-1:0] ratio;
  logic [CNT_W-1:0] pend_ratio;
  logic             pend_vld;
  logic [CNT_W-1:0] req_ratio;
  logic [CNT_W-1:0] new_ratio;
  logic [CNT_W-1:0] cnt_next;
  logic             req_now;
  logic             req_eff;
  logic             wrap;
  logic             run;
  logic             load;

`ifdef BW_CLK_CCLK_DIV_STOP_EN
  logic [1:0] state;
  logic [1:0] state_nx;

  // Stop FSM. A stop request seen on a boundary edge parks at once, so the
  // stop latency never exceeds one period; STOPPING just waits for that edge.
  always_comb begin
    req_now   = div_req & ~div_ack;
    req_ratio = CNT_W'(clamp_ratio(32'(div_ratio)));
    req_eff   = pend_vld | req_now;
    new_ratio = pend_vld ? pend_ratio : req_ratio;
    wrap      = (cnt_next == '0);
    state_nx  = state;
    run       = 1'b1;
    case (state)
      ST_RUN: begin
        if (stop_req) begin
          if (wrap) begin
            state_nx = ST_STOPPED;
            run      = 1'b0;
          end else begin
            state_nx = ST_STOPPING;
          end
        end
      end
      ST_STOPPING: begin
        if (!stop_req) begin
          state_nx = ST_RUN;
        end else if (wrap) begin
          state_nx = ST_STOPPED;
          run      = 1'b0;
        end
      end
      ST_STOPPED: begin
        if (!stop_req) begin
          state_nx = ST_RUN;
        end else begin
          run = 1'b0;
        end
      end
      default: state_nx = ST_RUN;
    endcase
    load = req_eff & ((state == ST_STOPPED) | wrap);
  end

  // State register and the registered stopped flag.
  always_ff @(posedge gclk or posedge arst) begin
    if (arst) begin
      state   <= ST_RUN;
      stopped <= 1'b0;
    end else begin
      state   <= state_nx;
      stopped <= (state_nx == ST_STOPPED);
    end
  end
`else
  logic stop_req_unused;

  // Always running: ratio loads only on period boundaries.
  always_comb begin
    req_now   = div_req & ~div_ack;
    req_ratio = CNT_W'(clamp_ratio(32'(div_ratio)));
    req_eff   = pend_vld | req_now;
    new_ratio = pend_vld ? pend_ratio : req_ratio;
    wrap      = (cnt_next == '0);
    run       = 1'b1;
    load      = req_eff & wrap;
  end

  assign stop_req_unused = stop_req;
  assign stopped         = 1'b0;
`endif

  // Ratio handshake: hold a pending request until a load edge, then ack once.
  always_ff @(posedge gclk or posedge arst) begin
    if (arst) begin
      ratio      <= CNT_W'(DIV_RST);
      pend_ratio <= CNT_W'(DIV_RST);
      pend_vld   <= 1'b0;
      div_ack    <= 1'b0;
    end else begin
      div_ack <= load;
      if (load) begin
        ratio    <= new_ratio;
        pend_vld <= 1'b0;
      end else if (req_now) begin
        pend_vld   <= 1'b1;
        pend_ratio <= req_ratio;
      end
    end
  end

  bw_clk_cclk_div_cnt #(
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) u_cnt (
    .gclk      (gclk),
    .arst      (arst),
    .n         (ratio),
    .n_new     (new_ratio),
    .run       (run),
    .load      (load),
    .cnt_next  (cnt_next),
    .cclk_div  (cclk_div),
    .cyc_start (cyc_start)
  );

endmodule

// File: tb/tb_bw_clk_cclk_div.sv
// Self-checking bench for bw_clk_cclk_div: directed scenarios with literal
// expectations followed by a randomized phase, all outputs compared every
// cycle against a period-level behavioural model.
module tb_bw_clk_cclk_div;

  localparam int CNT_W   = 4;
  localparam int DIV_RST = 2;
`ifdef BW_CLK_CCLK_DIV_STOP_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic             gclk;
  logic             arst;
  logic [CNT_W-1:0] div_ratio;
  logic             div_req;
  logic             div_ack;
  logic             stop_req;
  logic             stopped;
  logic             cclk_div;
  logic             cyc_start;

  int compared   = 0;
  int mismatched = 0;

  bw_clk_cclk_div #(
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) dut (
    .gclk      (gclk),
    .arst      (arst),
    .div_ratio (div_ratio),
    .div_req   (div_req),
    .div_ack   (div_ack),
    .stop_req  (stop_req),
    .stopped   (stopped),
    .cclk_div  (cclk_div),
    .cyc_start (cyc_start)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // Behavioural model: position within the current period, ratio in effect,
  // one pending request and a parked flag.
  int m_n;
  int m_pos;
  bit m_parked;
  bit m_pend;
  int m_pend_n;
  bit m_req_now;
  int m_req_n;
  bit m_boundary;
  bit m_load;
  bit exp_cclk    = 1'b0;
  bit exp_cs      = 1'b0;
  bit exp_ack     = 1'b0;
  bit exp_stopped = 1'b0;

  always @(posedge gclk or posedge arst) begin
    if (arst) begin
      m_n         = DIV_RST;
      m_pos       = DIV_RST - 1;
      m_parked    = 1'b0;
      m_pend      = 1'b0;
      m_pend_n    = DIV_RST;
      exp_cclk    = 1'b0;
      exp_cs      = 1'b0;
      exp_ack     = 1'b0;
      exp_stopped = 1'b0;
    end else begin
      m_req_now  = div_req && !exp_ack;
      m_req_n    = (int'(div_ratio) < 2) ? 2 : int'(div_ratio);
      m_boundary = m_parked || (m_pos == m_n - 1);
      m_load     = (m_pend || m_req_now) && m_boundary;
      if (m_load) begin
        m_n    = m_pend ? m_pend_n : m_req_n;
        m_pend = 1'b0;
      end else if (m_req_now) begin
        m_pend   = 1'b1;
        m_pend_n = m_req_n;
      end
      exp_ack = m_load;
      if (m_boundary && STOP_EN && stop_req) begin
        m_parked = 1'b1;
        exp_cclk = 1'b0;
        exp_cs   = 1'b0;
      end else if (m_boundary) begin
        m_parked = 1'b0;
        m_pos    = 0;
        exp_cclk = 1'b1;
        exp_cs   = 1'b1;
      end else begin
        m_pos    = m_pos + 1;
        exp_cclk = (m_pos < (m_n + 1) / 2);
        exp_cs   = 1'b0;
      end
      exp_stopped = m_parked;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, away from the active edge, compare all outputs with the model.
  always @(negedge gclk) begin
    check_output("cclk_div", 32'(cclk_div), 32'(exp_cclk));
    check_output("cyc_start", 32'(cyc_start), 32'(exp_cs));
    check_output("div_ack", 32'(div_ack), 32'(exp_ack));
    check_output("stopped", 32'(stopped), 32'(exp_stopped));
  end

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  // Tick len times, recording DUT cclk/cyc_start/ack and model cclk (MSB first).
  task automatic collect(input int len, output logic [15:0] pd, output logic [15:0] pm,
                         output logic [15:0] pc, output logic [15:0] pa);
    pd = '0; pm = '0; pc = '0; pa = '0;
    for (int i = 0; i < len; i++) begin
      tick();
      pd[len-1-i] = cclk_div;
      pm[len-1-i] = exp_cclk;
      pc[len-1-i] = cyc_start;
      pa[len-1-i] = div_ack;
    end
  endtask

  // Raise a request, wait (bounded) for ack, record cclk from the ack cycle on,
  // and drop the request the cycle after the ack.
  task automatic do_request(input int ratio, input int len, output int lat,
                            output logic [15:0] pd, output logic [15:0] pm);
    div_ratio = CNT_W'(ratio);
    div_req   = 1'b1;
    lat       = 0;
    do begin
      tick();
      lat++;
    end while (!div_ack && lat < 64);
    pd = '0; pm = '0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) tick();
      if (i == 1) div_req = 1'b0;
      pd[len-1-i] = cclk_div;
      pm[len-1-i] = exp_cclk;
    end
    div_req = 1'b0;
  endtask

  task automatic apply_stimulus();
    logic [15:0] pd, pm, pc, pa;
    int lat;
    bit ack_hold;

    arst = 1'b1; div_req = 1'b0; div_ratio = '0; stop_req = 1'b0;
    repeat (3) tick();
    check_output("rst_cclk_div", 32'(cclk_div), 32'd0);
    check_output("rst_cyc_start", 32'(cyc_start), 32'd0);
    check_output("rst_stopped", 32'(stopped), 32'd0);
    check_output("rst_div_ack", 32'(div_ack), 32'd0);
    arst = 1'b0;

    // Divide by two straight out of reset.
    collect(8, pd, pm, pc, pa);
    check_output("div2_cclk", 32'(pd[7:0]), 32'h0AA);
    check_output("div2_cyc_start", 32'(pc[7:0]), 32'h0AA);
    check_output("div2_model", 32'(pm[7:0]), 32'h0AA);

    // Ratio 3 requested mid-period.
    tick();
    do_request(3, 6, lat, pd, pm);
    check_output("n3_ack_latency", 32'(lat), 32'd2);
    check_output("n3_cclk", 32'(pd[5:0]), 32'b110110);
    check_output("n3_model", 32'(pm[5:0]), 32'b110110);

    // Ratio 5 requested on a boundary, then 4 requested at cnt=1.
    do_request(5, 5, lat, pd, pm);
    check_output("n5_ack_latency", 32'(lat), 32'd1);
    check_output("n5_cclk", 32'(pd[4:0]), 32'b11100);
    tick();
    tick();
    do_request(4, 8, lat, pd, pm);
    check_output("n4_ack_latency", 32'(lat), 32'd4);
    check_output("n4_cclk", 32'(pd[7:0]), 32'b11001100);
    check_output("n4_model", 32'(pm[7:0]), 32'b11001100);

`ifdef BW_CLK_CCLK_DIV_STOP_EN
    // Stop requested at cnt=0 with N=4.
    tick();
    stop_req = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!stopped && lat < 64);
    check_output("stop_latency", 32'(lat), 32'd4);
    check_output("stop_cclk", 32'(cclk_div), 32'd0);
    tick();
    tick();
    check_output("parked_cclk", 32'(cclk_div), 32'd0);
    check_output("parked_stopped", 32'(stopped), 32'd1);

    // Ratio 7 while parked, then restart.
    do_request(7, 2, lat, pd, pm);
    check_output("n7_ack_latency", 32'(lat), 32'd1);
    check_output("n7_parked_cclk", 32'(pd[1:0]), 32'b00);
    stop_req = 1'b0;
    collect(7, pd, pm, pc, pa);
    check_output("n7_cclk", 32'(pd[6:0]), 32'b1111000);
    check_output("n7_cyc_start", 32'(pc[6:0]), 32'b1000000);
    check_output("n7_model", 32'(pm[6:0]), 32'b1111000);
    check_output("restart_stopped", 32'(stopped), 32'd0);
`endif

    // Reset pulsed while stopping with a request pending.
    tick();
    stop_req = 1'b1;
    div_ratio = 4'd9;
    div_req = 1'b1;
    tick();
    tick();
    arst = 1'b1;
    #2;
    check_output("arst_cclk_div", 32'(cclk_div), 32'd0);
    check_output("arst_cyc_start", 32'(cyc_start), 32'd0);
    check_output("arst_div_ack", 32'(div_ack), 32'd0);
    check_output("arst_stopped", 32'(stopped), 32'd0);
    div_req = 1'b0;
    stop_req = 1'b0;
    tick();
    arst = 1'b0;
    collect(6, pd, pm, pc, pa);
    check_output("post_arst_cclk", 32'(pd[5:0]), 32'b101010);
    check_output("post_arst_ack", 32'(pa[5:0]), 32'd0);

    // Randomized phase: requests, stop bursts and rare resets.
    ack_hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 499) == 0) begin
        arst = 1'b1;
        div_req = 1'b0;
        ack_hold = 1'b0;
        tick();
        arst = 1'b0;
      end else begin
        if (div_req) begin
          if (ack_hold) begin
            div_req = 1'b0;
            ack_hold = 1'b0;
          end else if (exp_ack) begin
            ack_hold = 1'b1;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          div_ratio = CNT_W'($urandom_range(0, 15));
          div_req = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) stop_req = ~stop_req;
      end
    end
    div_req = 1'b0;
    stop_req = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    apply_stimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
